// File: rtl/game_display_bridge.sv
// Glue between game core, board buttons and VGA controller: button conditioning,
// a pausable speed-selectable game tick, and a frame-synchronised snapshot buffer.
module game_display_bridge #(
  parameter int NUM_BTN         = 5,
  parameter int PAUSE_IDX       = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_DIV        = 5000000,
  parameter int STATE_W         = 160,
  parameter int DROP_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               paused,
  input  logic [1:0]         speed_sel,
  output logic               game_tick,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [STATE_W-1:0] upd_state,
  input  logic               frame_start,
  output logic [STATE_W-1:0] disp_state,
  output logic               disp_valid,
  output logic [DROP_W-1:0]  drop_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_EMPTY, S_PENDING} snap_state_t;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] stable_q, stable_d, stable_dly_q;
  logic [NUM_BTN-1:0] pulse_q;
  logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
  logic               paused_q, upd_ready_q;
  logic [TK_W-1:0]    tick_cnt_q, tick_cnt_d, tick_limit;
  logic               tick;

  snap_state_t        state_q, state_d;
  logic [STATE_W-1:0] pending_q, pending_d, disp_q, disp_d;
  logic               disp_valid_q, disp_valid_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               xfer;

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive synced samples that disagree with the stable level.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // >= rather than == lets a shorter period take effect without overrun.
  assign tick_limit = TK_W'((TICK_DIV >> speed_sel) - 1);
  assign tick       = ~paused_q & (tick_cnt_q >= tick_limit);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!paused_q) tick_cnt_d = tick ? '0 : tick_cnt_q + TK_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pulse_q      <= '0;
      paused_q     <= 1'b0;
      upd_ready_q  <= 1'b0;
      tick_cnt_q   <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pulse_q      <= stable_q & ~stable_dly_q;
      paused_q     <= paused_q ^ pulse_q[PAUSE_IDX];
      upd_ready_q  <= ~paused_q;
      tick_cnt_q   <= tick_cnt_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign xfer = upd_valid & upd_ready_q;

  // Snapshot buffer: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_EMPTY;
      pending_q    <= '0;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
      drop_q       <= drop_d;
    end
  end

  // Snapshot buffer: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY:   if (xfer) state_d = S_PENDING;
      S_PENDING: if (frame_start && !xfer) state_d = S_EMPTY;
      default:   state_d = S_EMPTY;
    endcase
  end

  // Snapshot buffer: datapath; a transfer with frame_start in EMPTY only
  // fills pending, so it shows at the following frame.
  always_comb begin
    pending_d    = pending_q;
    disp_d       = disp_q;
    disp_valid_d = disp_valid_q;
    drop_d       = drop_q;
    if (xfer) pending_d = upd_state;
    if (state_q == S_PENDING) begin
      if (frame_start) begin
        disp_d       = pending_q;
        disp_valid_d = 1'b1;
      end else if (xfer && drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  assign btn_level  = stable_q;
  assign btn_pulse  = pulse_q;
  assign paused     = paused_q;
  assign upd_ready  = upd_ready_q;
  assign game_tick  = tick;
  assign disp_state = disp_q;
  assign disp_valid = disp_valid_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_game_display_bridge.sv
// Self-checking bench for game_display_bridge: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_game_display_bridge;
  localparam int NB = 5, PIDX = 4, DB = 4, TDIV = 16, SW = 160, DW = 8;

  logic          clk = 1'b0, reset = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_pulse;
  logic          paused, game_tick, upd_ready, disp_valid;
  logic [1:0]    speed_sel = '0;
  logic          upd_valid = 1'b0, frame_start = 1'b0;
  logic [SW-1:0] upd_state = '0, disp_state;
  logic [DW-1:0] drop_count;

  game_display_bridge #(.NUM_BTN(NB), .PAUSE_IDX(PIDX), .DEBOUNCE_CYCLES(DB),
                        .TICK_DIV(TDIV), .STATE_W(SW), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_pulse(btn_pulse), .paused(paused), .speed_sel(speed_sel),
    .game_tick(game_tick), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_state(upd_state), .frame_start(frame_start), .disp_state(disp_state),
    .disp_valid(disp_valid), .drop_count(drop_count));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // Behavioural model state
  logic [NB-1:0] m_s1, m_s2, m_stable, m_rose, m_pulse;
  int            m_run [NB];
  logic          m_paused, m_ready, m_last_tick, m_dv;
  int            m_cnt, m_drop;
  logic [SW-1:0] m_disp;
  logic [SW-1:0] pend [$];
  logic          obs_tick;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_rose = '0; m_pulse = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    m_paused = 1'b0; m_ready = 1'b0; m_last_tick = 1'b0; m_dv = 1'b0;
    m_cnt = 0; m_drop = 0; m_disp = '0;
    pend.delete();
  endtask

  task automatic model_edge();
    int limit;
    logic xfer;
    logic [NB-1:0] rose_n;
    limit = (TDIV >> speed_sel) - 1;
    m_last_tick = !m_paused && (m_cnt >= limit);
    xfer = upd_valid && m_ready;
    if (frame_start && pend.size() != 0) begin
      m_disp = pend.pop_front();
      m_dv = 1'b1;
    end
    if (xfer) begin
      if (pend.size() != 0 && m_drop < 255) m_drop++;
      pend.delete();
      pend.push_back(upd_state);
    end
    if (!m_paused) m_cnt = m_last_tick ? 0 : m_cnt + 1;
    m_ready = !m_paused;
    m_paused = m_paused ^ m_pulse[PIDX];
    m_pulse = m_rose;
    rose_n = '0;
    for (int i = 0; i < NB; i++) begin
      if (m_s2[i] != m_stable[i]) begin
        if (m_run[i] == DB - 1) begin
          m_stable[i] = m_s2[i];
          m_run[i] = 0;
          rose_n[i] = m_s2[i];
        end else m_run[i]++;
      end else m_run[i] = 0;
    end
    m_rose = rose_n;
    m_s2 = m_s1;
    m_s1 = btn_raw;
  endtask

  // One clock: sample combinational tick away from the edge, advance model, settle.
  task automatic cycle();
    @(negedge clk);
    obs_tick = game_tick;
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] r;
    for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0; btn_raw = '0; upd_valid = 1'b0; frame_start = 1'b0; speed_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (btn_level !== '0) begin n_fail++; $display("FAIL rst_level got %0h want 0", btn_level); end
    n_checks++; if (btn_pulse !== '0) begin n_fail++; $display("FAIL rst_pulse got %0h want 0", btn_pulse); end
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL rst_paused got %0b want 0", paused); end
    n_checks++; if (game_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %0b want 0", game_tick); end
    n_checks++; if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0b want 0", upd_ready); end
    n_checks++; if (disp_state !== '0) begin n_fail++; $display("FAIL rst_disp got %0h want 0", disp_state); end
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dvalid got %0b want 0", disp_valid); end
    n_checks++; if (drop_count !== '0) begin n_fail++; $display("FAIL rst_drop got %0d want 0", drop_count); end
    reset = 1'b1;
    cycle();
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %0b want 1", upd_ready); end
    n_checks++; if (obs_tick !== 1'b0) begin n_fail++; $display("FAIL rel_tick got %0b want 0", obs_tick); end
  endtask

  task automatic test_debounce_latency();
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      n_checks++;
      if (btn_pulse[0] !== (k == 7)) begin
        n_fail++; $display("FAIL pulse_lat edge %0d got %0b want %0b", k, btn_pulse[0], (k == 7));
      end
    end
    n_checks++; if (btn_level[0] !== 1'b1) begin n_fail++; $display("FAIL level_hi got %0b want 1", btn_level[0]); end
    btn_raw[0] = 1'b0;
    repeat (DB + 4) cycle();
    n_checks++; if (btn_level[0] !== 1'b0) begin n_fail++; $display("FAIL level_lo got %0b want 0", btn_level[0]); end
    n_checks++; if (btn_pulse !== m_pulse) begin n_fail++; $display("FAIL pulse_fall got %0h want %0h", btn_pulse, m_pulse); end
  endtask

  task automatic test_glitch();
    btn_raw[1] = 1'b1;
    repeat (DB - 1) cycle();
    btn_raw[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      n_checks++;
      if (btn_pulse[1] !== 1'b0 || btn_level[1] !== 1'b0) begin
        n_fail++; $display("FAIL glitch cyc %0d got pulse %0b level %0b want 0 0", k, btn_pulse[1], btn_level[1]);
      end
    end
  endtask

  task automatic test_tick();
    int last, k;
    speed_sel = 2'd0;
    last = -1;
    for (k = 0; k < 80; k++) begin
      cycle();
      n_checks++;
      if (obs_tick !== m_last_tick) begin n_fail++; $display("FAIL tick16 cyc %0d got %0b want %0b", k, obs_tick, m_last_tick); end
      if (obs_tick === 1'b1) begin
        if (last >= 0) begin
          n_checks++;
          if (k - last != 16) begin n_fail++; $display("FAIL tick16_gap got %0d want 16", k - last); end
        end
        last = k;
      end
    end
    for (k = 0; k < 40 && m_cnt != 10; k++) cycle();
    if (m_cnt != 10) begin
      n_checks++; n_fail++; $display("FAIL tick_sync got cnt %0d want 10", m_cnt);
    end
    speed_sel = 2'd2;
    cycle();
    n_checks++; if (obs_tick !== 1'b1) begin n_fail++; $display("FAIL speed_switch got %0b want 1", obs_tick); end
    last = 0;
    for (k = 1; k <= 20; k++) begin
      cycle();
      n_checks++;
      if (obs_tick !== m_last_tick) begin n_fail++; $display("FAIL tick4 cyc %0d got %0b want %0b", k, obs_tick, m_last_tick); end
      if (obs_tick === 1'b1) begin
        n_checks++;
        if (k - last != 4) begin n_fail++; $display("FAIL tick4_gap got %0d want 4", k - last); end
        last = k;
      end
    end
  endtask

  task automatic press_pause();
    btn_raw[PIDX] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) btn_raw[PIDX] = 1'b0;
      cycle();
      n_checks++;
      if (obs_tick !== m_last_tick) begin n_fail++; $display("FAIL pause_tick cyc %0d got %0b want %0b", k, obs_tick, m_last_tick); end
    end
  endtask

  task automatic test_pause();
    int ticks;
    press_pause();
    n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL paused_on got %0b want 1", paused); end
    n_checks++; if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_off got %0b want 0", upd_ready); end
    ticks = 0;
    repeat (100) begin
      cycle();
      if (obs_tick === 1'b1) ticks++;
    end
    n_checks++; if (ticks != 0) begin n_fail++; $display("FAIL paused_ticks got %0d want 0", ticks); end
    press_pause();
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL paused_off got %0b want 0", paused); end
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_on got %0b want 1", upd_ready); end
    for (int k = 0; k < 12; k++) begin
      cycle();
      n_checks++;
      if (obs_tick !== m_last_tick) begin n_fail++; $display("FAIL resume_tick cyc %0d got %0b want %0b", k, obs_tick, m_last_tick); end
    end
  endtask

  task automatic test_snapshot();
    logic [SW-1:0] pa, pc, p1;
    pa = {20{8'hA5}}; pc = {20{8'h3C}}; p1 = {20{8'h11}};
    upd_valid = 1'b1; upd_state = pa; cycle();
    upd_state = pc; cycle();
    upd_valid = 1'b0;
    n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_one got %0d want 1", drop_count); end
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL dvalid_pre got %0b want 0", disp_valid); end
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    n_checks++; if (disp_state !== pc) begin n_fail++; $display("FAIL disp_latest got %0h want %0h", disp_state, pc); end
    n_checks++; if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL dvalid got %0b want 1", disp_valid); end
    upd_state = rand_state(); frame_start = 1'b1; cycle(); frame_start = 1'b0;
    n_checks++; if (disp_state !== pc) begin n_fail++; $display("FAIL empty_hold got %0h want %0h", disp_state, pc); end
    upd_valid = 1'b1; upd_state = p1; frame_start = 1'b1; cycle();
    upd_valid = 1'b0; frame_start = 1'b0;
    n_checks++; if (disp_state !== pc) begin n_fail++; $display("FAIL same_cyc got %0h want %0h", disp_state, pc); end
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    n_checks++; if (disp_state !== p1) begin n_fail++; $display("FAIL next_frame got %0h want %0h", disp_state, p1); end
    n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_keep got %0d want 1", drop_count); end
  endtask

  task automatic test_saturate();
    upd_valid = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      upd_state = rand_state();
      cycle();
      if (k == 100) begin
        n_checks++; if (drop_count !== 8'd100) begin n_fail++; $display("FAIL drop_100 got %0d want 100", drop_count); end
      end
    end
    upd_valid = 1'b0;
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL drop_sat got %0d want 255", drop_count); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    #1;
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_dvalid got %0b want 0", disp_valid); end
    n_checks++; if (drop_count !== '0) begin n_fail++; $display("FAIL mid_drop got %0d want 0", drop_count); end
    n_checks++; if (disp_state !== '0) begin n_fail++; $display("FAIL mid_disp got %0h want 0", disp_state); end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL discard_dvalid got %0b want 0", disp_valid); end
    n_checks++; if (disp_state !== '0) begin n_fail++; $display("FAIL discard_disp got %0h want 0", disp_state); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NB - 1; i++) if ($urandom_range(7) == 0) btn_raw[i] = ~btn_raw[i];
      if ($urandom_range(39) == 0) btn_raw[PIDX] = ~btn_raw[PIDX];
      upd_valid   = 1'($urandom_range(1));
      frame_start = ($urandom_range(9) == 0);
      upd_state   = rand_state();
      if ($urandom_range(63) == 0) speed_sel = 2'($urandom_range(3));
      cycle();
      n_checks++; if (obs_tick !== m_last_tick) begin n_fail++; $display("FAIL rnd_tick cyc %0d got %0b want %0b", k, obs_tick, m_last_tick); end
      n_checks++; if (btn_level !== m_stable) begin n_fail++; $display("FAIL rnd_level cyc %0d got %0h want %0h", k, btn_level, m_stable); end
      n_checks++; if (btn_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse cyc %0d got %0h want %0h", k, btn_pulse, m_pulse); end
      n_checks++; if (paused !== m_paused) begin n_fail++; $display("FAIL rnd_paused cyc %0d got %0b want %0b", k, paused, m_paused); end
      n_checks++; if (upd_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", k, upd_ready, m_ready); end
      n_checks++; if (disp_state !== m_disp) begin n_fail++; $display("FAIL rnd_disp cyc %0d got %0h want %0h", k, disp_state, m_disp); end
      n_checks++; if (disp_valid !== m_dv) begin n_fail++; $display("FAIL rnd_dvalid cyc %0d got %0b want %0b", k, disp_valid, m_dv); end
      n_checks++; if (drop_count !== DW'(m_drop)) begin n_fail++; $display("FAIL rnd_drop cyc %0d got %0d want %0d", k, drop_count, m_drop); end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_tick();
    test_pause();
    test_snapshot();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/game_display_bridge.md
Name: game_display_bridge

Overview:
- Parametrised successor to the snake-game/VGA top-level glue: it sits between the game core, the raw board buttons and the VGA controller.
- Conditions N buttons (synchronise, debounce, edge-detect) and generates a pausable, speed-selectable game step tick.
- Double-buffers the game-state bundle so the VGA controller only sees a new snapshot at frame start, which removes mid-frame tearing.

Parameters:
- NUM_BTN, 5, number of button channels (index 0..3 = up/down/left/right, index 4 = pause).
- PAUSE_IDX, 4, button index that toggles pause.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button level change; must be ≥1.
- TICK_DIV, 5000000, base clk cycles per game tick at speed_sel=0; must be ≥8.
- STATE_W, 160, width of the packed game-state bundle: body, head, length, fruit, lives, score, high score, game_over.
- DROP_W, 8, width of the dropped-update counter.

Ports:
- clk  in  1  system clock, sole clock domain.
- reset  in  1  asynchronous active-low reset; 0 = in reset.
- btn_raw  in  NUM_BTN  raw asynchronous button levels.
- btn_level  out  NUM_BTN  debounced button levels.
- btn_pulse  out  NUM_BTN  one-cycle pulse on each debounced 0→1 transition.
- paused  out  1  pause state.
- speed_sel  in  2  tick period = TICK_DIV >> speed_sel.
- game_tick  out  1  one-cycle game step strobe.
- upd_valid  in  1  game core offers a new state snapshot.
- upd_ready  out  1  bridge accepts a snapshot this cycle.
- upd_state  in  STATE_W  snapshot data.
- frame_start  in  1  one-cycle pulse from the VGA controller at the start of vertical blank.
- disp_state  out  STATE_W  snapshot currently shown.
- disp_valid  out  1  at least one snapshot has been displayed since reset.
- drop_count  out  DROP_W  saturating count of overwritten, never-displayed snapshots.

Behaviour:
- Reset values: all outputs 0, internal counters 0, pending buffer empty.
- Reset deassertion mid-operation restarts every channel from these values.
- Button path, per channel:
  - 2-flop synchroniser feeds a debounce counter.
  - Counter increments while synced ≠ stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with synced ≠ stable, stable ← synced on that edge and the counter clears.
  - btn_level = stable.
  - btn_pulse is high for exactly one cycle, registered, on the cycle after stable goes 0→1.
  - Total latency from the first edge sampling raw high to btn_pulse high = DEBOUNCE_CYCLES+3 edges.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
- Pause: paused toggles on btn_pulse[PAUSE_IDX].
- Tick generator:
  - limit = (TICK_DIV >> speed_sel) - 1.
  - Counter increments each cycle while paused=0.
  - When counter ≥ limit: counter ← 0 and game_tick=1 for that cycle.
  - Using ≥ means a speed_sel decrease of the period takes effect at once, with no counter overrun.
  - While paused=1 the counter holds and game_tick=0.
  - A pause toggle in the same cycle as a wrap: the tick still issues, then the counter holds.
- Snapshot handshake:
  - upd_ready = ~paused (registered from paused).
  - A transfer occurs when upd_valid & upd_ready.
- FSM with states EMPTY and PENDING:
  - EMPTY + transfer → PENDING; pending ← upd_state.
  - PENDING + transfer without frame_start → PENDING; pending overwritten (latest wins); drop_count += 1, saturating at all-ones.
  - PENDING + frame_start → disp_state ← pending, disp_valid ← 1.
    - With a simultaneous transfer: pending ← upd_state, stay PENDING, no drop counted.
    - Without a transfer: → EMPTY.
  - EMPTY + frame_start → no change; disp_state holds.
  - EMPTY + frame_start + transfer → PENDING; the data becomes visible at the next frame_start, not this one.
- disp_state changes only on a clk edge where frame_start=1, so it is stable for the whole active frame.
- Latency from transfer to display: next frame_start strictly after the transfer cycle, plus 1 edge.

Test Plan:
- Reset release with all inputs 0 → every output 0.
- Raw glitch shorter than DEBOUNCE_CYCLES → no btn_pulse.
- DEBOUNCE_CYCLES=4, btn_raw[0] rises and stays high → btn_pulse[0] high for 1 cycle exactly 7 edges later; btn_level[0]=1 thereafter.
- TICK_DIV=16, speed_sel=0 → game_tick every 16 cycles.
- Same configuration, switch to speed_sel=2 when counter=10 → tick on the next cycle, then every 4 cycles.
- Pulse btn_raw[4] → paused=1 and upd_ready=0, no ticks for 100 cycles; pulse again → ticks resume with the counter value preserved.
- Transfer 0xA5.., then 0x3C.. before frame_start → drop_count=1; frame_start → disp_state=0x3C.., disp_valid=1, FSM EMPTY.
- Transfer 0x11.. in the same cycle as frame_start with FSM EMPTY → disp_state unchanged; next frame_start → disp_state=0x11...
- 300 overwrites with no frame_start → drop_count saturates at 255.
- Assert reset low mid-PENDING → disp_valid=0, drop_count=0, pending discarded.
